// File: rtl/apuf_eval_ctrl.sv
// apuf_eval_ctrl: evaluation controller for a k-XOR arbiter PUF, with a per-channel majority vote over REPEATS evaluations.
// Latency: rsp_valid rises REPEATS*(RESET_CYCLES+SETTLE_CYCLES+1) cycles after the accept edge.
// Backpressure: one request in flight; req_ready stays low until rsp_ready takes the response.
// Optional build macro APUF_STABILITY_EN: adds rsp_unstable, which flags channels whose vote was not unanimous.
module apuf_eval_ctrl #(
  parameter int LINE_LENGTH   = 64,
  parameter int CHANNELS      = 4,
  parameter int REPEATS       = 7,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LINE_LENGTH-1:0] req_challenge,
  output logic [LINE_LENGTH-1:0] dl_challenge,
  output logic                   dl_launch,
  input  logic [CHANNELS-1:0]    dl_arb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_bit,
  output logic [CHANNELS-1:0]    rsp_raw
`ifdef APUF_STABILITY_EN
  ,
  output logic [CHANNELS-1:0]    rsp_unstable
`endif
);

  // Vote counters must hold REPEATS. The phase counter only has to reach the longer phase length minus one.
  localparam int CW    = $clog2(REPEATS + 1);
  localparam int MAXPH = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PW    = (MAXPH > 1) ? $clog2(MAXPH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [PW-1:0]                 ph_q, ph_d;
  logic [CW-1:0]                 rep_q, rep_d;
  logic [CHANNELS-1:0][CW-1:0]   ones_q, ones_d;
  logic [LINE_LENGTH-1:0]        chal_q, chal_d;
  logic                          launch_q, launch_d;
  logic [CHANNELS-1:0]           arb_s1_q, arb_s1_d;
  logic [CHANNELS-1:0]           arb_s2_q, arb_s2_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [CHANNELS-1:0]           raw_q, raw_d;
  logic                          bit_q, bit_d;
`ifdef APUF_STABILITY_EN
  logic [CHANNELS-1:0]           unst_q, unst_d;
`endif

  logic                          accept;
  logic                          ph_last_low;
  logic                          ph_last_high;
  logic [CW-1:0]                 rep_inc;
  logic                          last_rep;
  logic [CHANNELS-1:0][CW-1:0]   ones_inc;
  logic [CHANNELS-1:0]           vote;

  assign accept       = req_valid && (state_q == ST_IDLE);
  assign ph_last_low  = (ph_q == PW'(RESET_CYCLES - 1));
  assign ph_last_high = (ph_q == PW'(SETTLE_CYCLES - 1));
  assign rep_inc      = rep_q + CW'(1);
  assign last_rep     = (rep_inc == CW'(REPEATS));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a LOW/HIGH/SAMPLE evaluation loop runs REPEATS times, then DONE waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid)    state_d = ST_LOW;
      ST_LOW:    if (ph_last_low)  state_d = ST_HIGH;
      ST_HIGH:   if (ph_last_high) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last_rep ? ST_DONE : ST_LOW;
      ST_DONE:   if (rsp_ready)    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: launch and valid are computed from the next state, so their flops line up with the state register
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    launch_d    = (state_d == ST_HIGH) || (state_d == ST_SAMPLE);
    rsp_valid_d = (state_d == ST_DONE);
  end

  // Phase timer: restarts on every state change and counts while the FSM stays in LOW or HIGH
  always_comb begin
    ph_d = ph_q;
    if (state_d != state_q) begin
      ph_d = '0;
    end else if ((state_q == ST_LOW) || (state_q == ST_HIGH)) begin
      ph_d = ph_q + PW'(1);
    end
  end

  // Datapath: latch the challenge, synchronise the arbiters, count ones, and form the vote on DONE entry
  always_comb begin
    chal_d   = chal_q;
    rep_d    = rep_q;
    ones_d   = ones_q;
    raw_d    = raw_q;
    bit_d    = bit_q;
    arb_s1_d = dl_arb;
    arb_s2_d = arb_s1_q;
`ifdef APUF_STABILITY_EN
    unst_d   = unst_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      ones_inc[i] = ones_q[i] + CW'(arb_s2_q[i]);
      vote[i]     = (ones_inc[i] > CW'(REPEATS / 2));
    end
    if (accept) begin
      chal_d = req_challenge;
      rep_d  = '0;
      ones_d = '0;
    end else if (state_q == ST_SAMPLE) begin
      rep_d  = rep_inc;
      ones_d = ones_inc;
      if (last_rep) begin
        raw_d = vote;
        bit_d = ^vote;
`ifdef APUF_STABILITY_EN
        for (int i = 0; i < CHANNELS; i++) begin
          unst_d[i] = (ones_inc[i] != '0) && (ones_inc[i] != CW'(REPEATS));
        end
`endif
      end
    end
  end

  // Datapath and output registers; the reset clears everything, including a response that is still pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q        <= '0;
      rep_q       <= '0;
      ones_q      <= '0;
      chal_q      <= '0;
      launch_q    <= 1'b0;
      arb_s1_q    <= '0;
      arb_s2_q    <= '0;
      rsp_valid_q <= 1'b0;
      raw_q       <= '0;
      bit_q       <= 1'b0;
`ifdef APUF_STABILITY_EN
      unst_q      <= '0;
`endif
    end else begin
      ph_q        <= ph_d;
      rep_q       <= rep_d;
      ones_q      <= ones_d;
      chal_q      <= chal_d;
      launch_q    <= launch_d;
      arb_s1_q    <= arb_s1_d;
      arb_s2_q    <= arb_s2_d;
      rsp_valid_q <= rsp_valid_d;
      raw_q       <= raw_d;
      bit_q       <= bit_d;
`ifdef APUF_STABILITY_EN
      unst_q      <= unst_d;
`endif
    end
  end

  assign dl_challenge = chal_q;
  assign dl_launch    = launch_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_raw      = raw_q;
  assign rsp_bit      = bit_q;
`ifdef APUF_STABILITY_EN
  assign rsp_unstable = unst_q;
`endif

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// tb_apuf_eval_ctrl: directed bench for apuf_eval_ctrl with REPEATS=3, RESET_CYCLES=2, SETTLE_CYCLES=3.
// It checks the launch pattern, latency, vote results, backpressure, mid-run reset and back-to-back requests.
// Inputs are driven and outputs sampled on the falling edge.
module tb_apuf_eval_ctrl;
  localparam int LL   = 64;
  localparam int CH   = 4;
  localparam int REP  = 3;
  localparam int RC   = 2;
  localparam int SC   = 3;
  localparam int EVAL = RC + SC + 1;
  localparam int LAT  = REP * EVAL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [LL-1:0] req_challenge = '0;
  logic [LL-1:0] dl_challenge;
  logic          dl_launch;
  logic [CH-1:0] dl_arb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_bit;
  logic [CH-1:0] rsp_raw;
`ifdef APUF_STABILITY_EN
  logic [CH-1:0] rsp_unstable;
`endif

  always #5 clk = ~clk;

  apuf_eval_ctrl #(
    .LINE_LENGTH(LL), .CHANNELS(CH), .REPEATS(REP),
    .RESET_CYCLES(RC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
    .dl_challenge(dl_challenge), .dl_launch(dl_launch), .dl_arb(dl_arb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit), .rsp_raw(rsp_raw)
`ifdef APUF_STABILITY_EN
    , .rsp_unstable(rsp_unstable)
`endif
  );

  typedef struct {
    logic [LL-1:0]         chal;
    logic [REP-1:0][CH-1:0] arb;   // arb[e] is the value driven during evaluation e
    logic [CH-1:0]         raw;
    logic                  bitv;
    logic [CH-1:0]         unst;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [LL-1:0] c, input logic [CH-1:0] a0, input logic [CH-1:0] a1,
                              input logic [CH-1:0] a2, input logic [CH-1:0] r, input logic b,
                              input logic [CH-1:0] u);
    vec_t v;
    v.chal = c; v.arb = {a2, a1, a0}; v.raw = r; v.bitv = b; v.unst = u;
    return v;
  endfunction

  // Called on a falling edge while the DUT is idle. Returns on the falling edge where rsp_valid is first
  // seen, and reports latency as the number of rising edges since the accept (-1 on timeout).
  task automatic run_txn(input logic [LL-1:0] chal, input logic [REP-1:0][CH-1:0] arb, output int lat);
    int errs_l;
    int errs_c;
    errs_l = 0;
    errs_c = 0;
    lat = -1;
    req_challenge = chal;
    req_valid = 1'b1;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = n - 1;
        break;
      end
      if (((n - 1) % EVAL == 0) && ((n - 1) / EVAL < REP)) dl_arb = arb[(n - 1) / EVAL];
      if (n <= LAT && dl_launch !== (((n - 1) % EVAL) >= RC)) errs_l++;
      if (dl_challenge !== chal || req_ready !== 1'b0) errs_c++;
    end
    chk("launch_pattern_errs", 64'(errs_l), 64'd0);
    chk("busy_chal_ready_errs", 64'(errs_c), 64'd0);
    chk("latency", 64'(lat), 64'(LAT));
  endtask

  task automatic chk_rsp(input vec_t v);
    chk("rsp_raw", 64'(rsp_raw), 64'(v.raw));
    chk("rsp_bit", 64'(rsp_bit), 64'(v.bitv));
`ifdef APUF_STABILITY_EN
    chk("rsp_unstable", 64'(rsp_unstable), 64'(v.unst));
`endif
  endtask

  initial begin
    int lat;
    vecs[0] = mk(64'hA5,                  4'b1010, 4'b1010, 4'b1010, 4'b1010, 1'b0, 4'b0000);
    vecs[1] = mk(64'h1234_5678_9ABC_DEF0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 4'b0001);
    vecs[2] = mk(64'hDEAD_BEEF_0000_0001, 4'b1010, 4'b1100, 4'b1100, 4'b1100, 1'b0, 4'b0110);
    vecs[3] = mk(64'hFFFF_FFFF_FFFF_FFFF, 4'b0111, 4'b0111, 4'b1111, 4'b0111, 1'b1, 4'b1000);
    vecs[4] = mk(64'h0,                   4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);

    // Reset state
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_dl_challenge", 64'(dl_challenge), 64'd0);
    chk("rst_dl_launch", 64'(dl_launch), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_bit", 64'(rsp_bit), 64'd0);
    chk("rst_rsp_raw", 64'(rsp_raw), 64'd0);
`ifdef APUF_STABILITY_EN
    chk("rst_rsp_unstable", 64'(rsp_unstable), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Table: back-to-back requests with rsp_ready held high
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_txn(vecs[k].chal, vecs[k].arb, lat);
      chk_rsp(vecs[k]);
      @(negedge clk);
      chk("pulse_rsp_valid_low", 64'(rsp_valid), 64'd0);
      chk("pulse_req_ready_high", 64'(req_ready), 64'd1);
      chk("chal_held_until_accept", dl_challenge, vecs[k].chal);
    end

    // Backpressure: the response is held for 10 cycles and request pulses are ignored meanwhile
    rsp_ready = 1'b0;
    run_txn(vecs[2].chal, vecs[2].arb, lat);
    for (int c = 0; c < 10; c++) begin
      req_valid = c[0];
      req_challenge = 64'h5555_0000_0000_0000 | 64'(c);
      @(negedge clk);
      chk("hold_vld_rdy_raw_bit", 64'({rsp_valid, req_ready, rsp_raw, rsp_bit}),
          64'({1'b1, 1'b0, vecs[2].raw, vecs[2].bitv}));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("release_req_ready", 64'(req_ready), 64'd1);
    chk("release_chal_kept", dl_challenge, vecs[2].chal);

    // Reset asserted during HIGH of the second evaluation
    req_challenge = vecs[3].chal;
    req_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0;
        dl_arb = 4'b1111;
      end
    end
    chk("pre_reset_launch_high", 64'(dl_launch), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dl_launch", 64'(dl_launch), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_rsp_raw", 64'(rsp_raw), 64'd0);
    chk("midrst_dl_challenge", 64'(dl_challenge), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(vecs[1].chal, vecs[1].arb, lat);
    chk_rsp(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
